// File: rtl/grf_write_arbiter_pkg.sv
// rtl/grf_write_arbiter_pkg.sv - shared widths, defaults, result record and helpers for the GRF write arbiter
package grf_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int WB_DEPTH = 2;
  localparam int WB_STARVE_LIMIT = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [31:0]           data;
    logic [31:0]           pc;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_W    = 2'd1,
    SRC_BUF  = 2'd2
  } src_e;

  function automatic logic [31:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    reg_onehot = 32'd1 << a;
  endfunction

endpackage

// File: rtl/grf_write_arbiter_if.sv
// rtl/grf_write_arbiter_if.sv - W stage, long-latency, decode query and GRF write port bundle
interface grf_write_arbiter_if;
  import grf_write_arbiter_pkg::*;

  logic                  w_en;
  logic [REG_ADDR_W-1:0] w_addr;
  logic [31:0]           w_data;
  logic [31:0]           w_pc;
  logic                  w_stall;

  logic                  a_valid;
  logic                  a_ready;
  logic [REG_ADDR_W-1:0] a_addr;
  logic [31:0]           a_data;
  logic [31:0]           a_pc;

  logic                  rsv_en;
  logic [REG_ADDR_W-1:0] rsv_addr;
  logic [REG_ADDR_W-1:0] q_addr0;
  logic [REG_ADDR_W-1:0] q_addr1;
  logic                  q_busy0;
  logic                  q_busy1;

  logic                  grf_we;
  logic [REG_ADDR_W-1:0] grf_waddr;
  logic [31:0]           grf_wdata;
  logic [31:0]           grf_wpc;

  modport master (
    output w_en, w_addr, w_data, w_pc, a_valid, a_addr, a_data, a_pc,
    output rsv_en, rsv_addr, q_addr0, q_addr1,
    input  w_stall, a_ready, q_busy0, q_busy1, grf_we, grf_waddr, grf_wdata, grf_wpc
  );

  modport slave (
    input  w_en, w_addr, w_data, w_pc, a_valid, a_addr, a_data, a_pc,
    input  rsv_en, rsv_addr, q_addr0, q_addr1,
    output w_stall, a_ready, q_busy0, q_busy1, grf_we, grf_waddr, grf_wdata, grf_wpc
  );

endinterface

// File: rtl/grf_write_arbiter_wb_fifo.sv
// rtl/grf_write_arbiter_wb_fifo.sv - DEPTH-entry FIFO holding long-latency results awaiting the write port
module grf_write_arbiter_wb_fifo
  import grf_write_arbiter_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output wb_entry_t        head
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO refuses a push even if it pops in the same cycle
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Result storage; contents are meaningless until counted in
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// rtl/grf_write_arbiter.sv - single-owner GRF write port arbiter with pending scoreboard (optional trace: GRF_WB_TRACE_EN)
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = WB_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input logic               clk,
  input logic               reset,
  grf_write_arbiter_if.slave bus
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]      count;
  wb_entry_t             head;
  wb_entry_t             push_entry;
  wb_entry_t             commit_entry;
  logic                  push;
  logic                  pop;
  logic                  nonempty;
  logic                  starve;
  logic                  a_ready;
  logic                  w_stall;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [31:0]           pending;
  logic [31:0]           pend_set;
  logic [31:0]           pend_clr;
  src_e                  sel;
  logic                  grf_we;
  logic [REG_ADDR_W-1:0] grf_waddr;
  logic [31:0]           grf_wdata;
  logic [31:0]           grf_wpc;

  assign nonempty   = (count != '0);
  assign a_ready    = (count < CNT_W'(DEPTH));
  assign push       = bus.a_valid && a_ready && (bus.a_addr != REG_ZERO);
  assign push_entry = '{addr: bus.a_addr, data: bus.a_data, pc: bus.a_pc};
  assign starve     = nonempty && (wait_cnt == WAIT_W'(STARVE_LIMIT));
  assign pop        = (sel == SRC_BUF);

  grf_write_arbiter_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

  // One winner per cycle: a starved buffer head beats the W stage, otherwise W stage first
  always_comb begin
    sel     = SRC_NONE;
    w_stall = 1'b0;
    if (starve) begin
      sel     = SRC_BUF;
      w_stall = bus.w_en;
    end else if (bus.w_en && (bus.w_addr != REG_ZERO)) begin
      sel = SRC_W;
    end else if (nonempty) begin
      sel = SRC_BUF;
    end
  end

  // Mux the selected write onto the commit path
  always_comb begin
    commit_entry = head;
    if (sel == SRC_W) commit_entry = '{addr: bus.w_addr, data: bus.w_data, pc: bus.w_pc};
  end

  // Count how long the buffer head has been passed over
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (pop || !nonempty) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_W'(STARVE_LIMIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Buffered entries never carry $0, so the head address is always a real register
  assign pend_set = (bus.rsv_en && (bus.rsv_addr != REG_ZERO)) ? reg_onehot(bus.rsv_addr) : 32'd0;
  assign pend_clr = pop ? reg_onehot(head.addr) : 32'd0;

  // Scoreboard of outstanding long-latency destinations; a new reservation wins over a retiring one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= 32'd0;
    else        pending <= (pending & ~pend_clr) | pend_set;
  end

  // Registered GRF write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we    <= 1'b0;
      grf_waddr <= '0;
      grf_wdata <= 32'd0;
      grf_wpc   <= 32'd0;
    end else begin
      grf_we <= (sel != SRC_NONE);
      if (sel != SRC_NONE) begin
        grf_waddr <= commit_entry.addr;
        grf_wdata <= commit_entry.data;
        grf_wpc   <= commit_entry.pc;
      end
    end
  end

`ifdef GRF_WB_TRACE_EN
  // Commit trace at the edge the write is captured
  always @(posedge clk) begin
    if (reset && (sel != SRC_NONE))
      $display("%d@%h: $%d <= %h", $time, commit_entry.pc, commit_entry.addr, commit_entry.data);
  end
`endif

  assign bus.a_ready   = a_ready;
  assign bus.w_stall   = w_stall;
  assign bus.q_busy0   = (bus.q_addr0 != REG_ZERO) && pending[bus.q_addr0];
  assign bus.q_busy1   = (bus.q_addr1 != REG_ZERO) && pending[bus.q_addr1];
  assign bus.grf_we    = grf_we;
  assign bus.grf_waddr = grf_waddr;
  assign bus.grf_wdata = grf_wdata;
  assign bus.grf_wpc   = grf_wpc;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// tb/tb_grf_write_arbiter.sv - self-checking bench: vector table, corner sequences, randomized reference model
module tb_grf_write_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  grf_write_arbiter_if bus ();

  grf_write_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       w_en;    logic [4:0] w_addr;  logic [31:0] w_data; logic [31:0] w_pc;
    logic       a_valid; logic [4:0] a_addr;  logic [31:0] a_data; logic [31:0] a_pc;
    logic       rsv_en;  logic [4:0] rsv_addr; logic [4:0] q0;     logic [4:0] q1;
    logic       e_ar;    logic       e_ws;    logic        e_b0;   logic        e_b1;
    logic       e_we;    logic [4:0] e_wa;    logic [31:0] e_wd;   logic [31:0] e_wp;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic w_en, input logic [4:0] w_addr, input logic [31:0] w_data,
                       input logic [31:0] w_pc, input logic a_valid, input logic [4:0] a_addr,
                       input logic [31:0] a_data, input logic [31:0] a_pc, input logic rsv_en,
                       input logic [4:0] rsv_addr, input logic [4:0] q0, input logic [4:0] q1);
    bus.w_en = w_en;     bus.w_addr = w_addr;   bus.w_data = w_data; bus.w_pc = w_pc;
    bus.a_valid = a_valid; bus.a_addr = a_addr; bus.a_data = a_data; bus.a_pc = a_pc;
    bus.rsv_en = rsv_en; bus.rsv_addr = rsv_addr; bus.q_addr0 = q0;  bus.q_addr1 = q1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  vec_t tbl[7];
  ent_t mq[$];
  bit [31:0] mpend;
  int mwait;

  initial begin
    // w_en addr data pc | a_valid addr data pc | rsv addr q0 q1 | ar ws b0 b1 | we wa wd wp
    tbl[0] = '{1, 5, 32'h1234, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5, 32'h1234, 32'h3000};
    tbl[1] = '{1, 0, 32'h5555, 32'h3004, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 1, 8, 32'hAA, 32'h4000, 0, 0, 8, 8, 1, 0, 1, 1, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 1, 0, 1, 0, 1, 8, 32'hAA, 32'h4000};
    tbl[5] = '{0, 0, 0, 0, 1, 0, 32'hDEAD, 32'h5000, 0, 0, 8, 8, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0};

    do_reset();
    #1;
    chk("rst_grf_we", bus.grf_we, 0);
    chk("rst_grf_waddr", bus.grf_waddr, 0);
    chk("rst_grf_wdata", bus.grf_wdata, 0);
    chk("rst_a_ready", bus.a_ready, 1);
    chk("rst_w_stall", bus.w_stall, 0);
    #1;

    // Vector table
    foreach (tbl[i]) begin
      drive(tbl[i].w_en, tbl[i].w_addr, tbl[i].w_data, tbl[i].w_pc, tbl[i].a_valid, tbl[i].a_addr,
            tbl[i].a_data, tbl[i].a_pc, tbl[i].rsv_en, tbl[i].rsv_addr, tbl[i].q0, tbl[i].q1);
      #1;
      chk($sformatf("vec%0d_a_ready", i), bus.a_ready, tbl[i].e_ar);
      chk($sformatf("vec%0d_w_stall", i), bus.w_stall, tbl[i].e_ws);
      chk($sformatf("vec%0d_busy0", i), bus.q_busy0, tbl[i].e_b0);
      chk($sformatf("vec%0d_busy1", i), bus.q_busy1, tbl[i].e_b1);
      tick();
      chk($sformatf("vec%0d_grf_we", i), bus.grf_we, tbl[i].e_we);
      if (tbl[i].e_we) begin
        chk($sformatf("vec%0d_waddr", i), bus.grf_waddr, tbl[i].e_wa);
        chk($sformatf("vec%0d_wdata", i), bus.grf_wdata, tbl[i].e_wd);
        chk($sformatf("vec%0d_wpc", i), bus.grf_wpc, tbl[i].e_wp);
      end
    end

    // Starvation: buffer fills while the W stage writes every cycle
    do_reset();
    drive(1, 3, 32'h33, 32'h100, 1, 10, 32'hA1, 32'h200, 0, 0, 0, 0);
    #1; chk("stv_c0_ws", bus.w_stall, 0); chk("stv_c0_ar", bus.a_ready, 1);
    tick(); chk("stv_c0_wa", bus.grf_waddr, 3);
    drive(1, 3, 32'h33, 32'h100, 1, 11, 32'hA2, 32'h204, 0, 0, 0, 0);
    #1; chk("stv_c1_ws", bus.w_stall, 0);
    tick(); chk("stv_c1_wa", bus.grf_waddr, 3);
    drive(1, 3, 32'h33, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i < 5; i++) begin
      #1; chk($sformatf("stv_c%0d_ar", i), bus.a_ready, 0); chk($sformatf("stv_c%0d_ws", i), bus.w_stall, 0);
      tick(); chk($sformatf("stv_c%0d_wa", i), bus.grf_waddr, 3);
    end
    #1; chk("stv_c5_ws", bus.w_stall, 1); chk("stv_c5_ar", bus.a_ready, 0);
    tick();
    chk("stv_c5_we", bus.grf_we, 1); chk("stv_c5_wa", bus.grf_waddr, 10);
    chk("stv_c5_wd", bus.grf_wdata, 32'hA1); chk("stv_c5_wp", bus.grf_wpc, 32'h200);
    #1; chk("stv_c6_ws", bus.w_stall, 0); chk("stv_c6_ar", bus.a_ready, 1);
    tick();
    chk("stv_c6_wa", bus.grf_waddr, 3); chk("stv_c6_wd", bus.grf_wdata, 32'h33); chk("stv_c6_wp", bus.grf_wpc, 32'h100);
    idle();
    tick(); chk("stv_c7_wa", bus.grf_waddr, 11); chk("stv_c7_wd", bus.grf_wdata, 32'hA2);
    tick(); chk("stv_c8_we", bus.grf_we, 0);

    // Reservation on the same edge the buffered result for that register retires
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    tick();
    drive(0, 0, 0, 0, 1, 9, 32'h99, 32'h300, 0, 0, 9, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    #1; chk("setwin_busy_pre", bus.q_busy0, 1);
    tick(); chk("setwin_we", bus.grf_we, 1); chk("setwin_wa", bus.grf_waddr, 9);
    idle(); bus.q_addr0 = 9;
    #1; chk("setwin_busy_post", bus.q_busy0, 1);

    // Asynchronous reset with two buffered results and two pending registers
    do_reset();
    drive(1, 1, 32'h11, 32'h10, 1, 8, 32'h88, 32'h20, 1, 8, 0, 0);
    tick();
    drive(1, 1, 32'h11, 32'h10, 1, 9, 32'h99, 32'h24, 1, 9, 0, 0);
    tick();
    drive(1, 1, 32'h11, 32'h10, 0, 0, 0, 0, 0, 0, 8, 9);
    #1; chk("mid_ar_full", bus.a_ready, 0); chk("mid_busy8", bus.q_busy0, 1); chk("mid_busy9", bus.q_busy1, 1);
    reset = 1'b0;
    #1;
    chk("arst_we", bus.grf_we, 0); chk("arst_ar", bus.a_ready, 1);
    chk("arst_busy8", bus.q_busy0, 0); chk("arst_busy9", bus.q_busy1, 0); chk("arst_ws", bus.w_stall, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 9);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("arst_after%0d_we", i), bus.grf_we, 0);
    end

    // Randomized traffic against a queue-based reference model
    do_reset();
    mq.delete();
    mpend = '0;
    mwait = 0;
    for (int n = 0; n < 400; n++) begin
      logic we, av, rv, e_ws, e_ar, ne, take_buf, take_w;
      logic [4:0] wa, aa, ra, q0, q1;
      logic [31:0] wd, wp, ad, ap;
      ent_t c;
      we = $urandom_range(0, 1); wa = 5'($urandom); wd = $urandom; wp = $urandom;
      av = $urandom_range(0, 1); aa = 5'($urandom); ad = $urandom; ap = $urandom;
      rv = ($urandom_range(0, 4) == 0); ra = 5'($urandom); q0 = 5'($urandom); q1 = 5'($urandom);
      if ($urandom_range(0, 7) == 0) wa = 0;
      if ($urandom_range(0, 7) == 0) aa = 0;
      if ($urandom_range(0, 5) == 0) q0 = 0;
      drive(we, wa, wd, wp, av, aa, ad, ap, rv, ra, q0, q1);
      ne = (mq.size() > 0);
      e_ar = (mq.size() < 2);
      e_ws = 0; take_buf = 0; take_w = 0;
      if (ne && mwait == 4) begin take_buf = 1; e_ws = we; end
      else if (we && wa != 0) take_w = 1;
      else if (ne) take_buf = 1;
      #1;
      chk("rnd_a_ready", bus.a_ready, e_ar);
      chk("rnd_w_stall", bus.w_stall, e_ws);
      chk("rnd_busy0", bus.q_busy0, (q0 != 0) && mpend[q0]);
      chk("rnd_busy1", bus.q_busy1, (q1 != 0) && mpend[q1]);
      tick();
      chk("rnd_grf_we", bus.grf_we, take_buf || take_w);
      if (take_buf) begin
        c = mq.pop_front();
        mpend[c.addr] = 1'b0;
      end else if (take_w) begin
        c = '{wa, wd, wp};
      end
      if (take_buf || take_w) begin
        chk("rnd_waddr", bus.grf_waddr, c.addr);
        chk("rnd_wdata", bus.grf_wdata, c.data);
        chk("rnd_wpc", bus.grf_wpc, c.pc);
      end
      if (av && e_ar && aa != 0) mq.push_back('{aa, ad, ap});
      if (rv && ra != 0) mpend[ra] = 1'b1;
      if (take_buf || !ne) mwait = 0;
      else if (mwait < 4) mwait++;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
